// File: rtl/fp8_pkg.sv
// Shared FP16 -> FP8 format constants, lane classes and the stage-1 lane record.
package fp8_pkg;

    localparam int unsigned FP16_BIAS = 15;
    localparam int unsigned E4M3_BIAS = 7;

    localparam logic [6:0] E4M3_MAX = 7'h7E;
    localparam logic [6:0] E4M3_NAN = 7'h7F;
    localparam logic [6:0] E5M2_MAX = 7'h7B;
    localparam logic [6:0] E5M2_INF = 7'h7C;
    localparam logic [6:0] E5M2_NAN = 7'h7E;

    typedef enum logic [2:0] {
        ClsZero,
        ClsSub,
        ClsNorm,
        ClsInf,
        ClsNan
    } lane_class_e;

    // body is {exponent, kept mantissa} pre-packed so rounding carries ripple into the exponent.
    typedef struct packed {
        logic        sign;
        lane_class_e cls;
        logic        e5m2;
        logic [7:0]  body;
        logic        guard;
        logic        rnd;
        logic        sticky;
    } s1_lane_t;

endpackage

// File: rtl/fp16_fp8_lane.sv
// One FP16 -> FP8 lane: stage 1 classifies and aligns, stage 2 rounds (RNE), clamps and packs.
module fp16_fp8_lane
    import fp8_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ld1_i,
    input  logic        ld2_i,
    input  logic [15:0] fp16_i,
    input  logic        e5m2_i,
    output logic [7:0]  fp8_o,
    output logic        sat_o
);

    localparam logic [4:0] E4M3_EXP_OFS = 5'(FP16_BIAS - E4M3_BIAS);

    logic [4:0]  exp16;
    logic [9:0]  man16;
    logic [10:0] sig;
    logic        e4_norm;
    logic [3:0]  shamt;
    logic [18:0] shr;
    s1_lane_t    s1_d, s1_q;

    logic        inc;
    logic [7:0]  sum;
    logic [7:0]  fp8_d, fp8_q;
    logic        sat_d, sat_q;

    always_comb begin
        exp16   = fp16_i[14:10];
        man16   = fp16_i[9:0];
        sig     = {exp16 != 5'd0, man16};
        e4_norm = exp16 > E4M3_EXP_OFS;

        s1_d      = '0;
        s1_d.sign = fp16_i[15];
        s1_d.e5m2 = e5m2_i;
        if (exp16 == 5'd0) begin
            s1_d.cls = (man16 == 10'd0) ? ClsZero : ClsSub;
        end else if (exp16 == 5'h1F) begin
            s1_d.cls = (man16 == 10'd0) ? ClsInf : ClsNan;
        end else begin
            s1_d.cls = ClsNorm;
        end

        // E4M3 subnormal results: one subnormal ulp is 2^-9, so the code is sig >> (16 - exp).
        if (e5m2_i) begin
            shamt = 4'd8;
        end else if (e4_norm) begin
            shamt = 4'd7;
        end else begin
            shamt = 4'(5'd16 - exp16);
        end
        shr = 19'({sig, 16'h0000} >> shamt);

        if (e5m2_i) begin
            s1_d.body = {1'b0, exp16, shr[17:16]};
        end else if (e4_norm) begin
            s1_d.body = {exp16 - E4M3_EXP_OFS, shr[18:16]};
        end else begin
            s1_d.body = {5'd0, shr[18:16]};
        end
        s1_d.guard  = shr[15];
        s1_d.rnd    = shr[14];
        s1_d.sticky = |shr[13:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
        end else if (ld1_i) begin
            s1_q <= s1_d;
        end
    end

    always_comb begin
        inc   = s1_q.guard & (s1_q.rnd | s1_q.sticky | s1_q.body[0]);
        sum   = s1_q.body + {7'd0, inc};
        fp8_d = {s1_q.sign, 7'h00};
        sat_d = 1'b0;
        if (s1_q.e5m2) begin
            case (s1_q.cls)
                ClsNan:  fp8_d[6:0] = E5M2_NAN;
                ClsInf:  fp8_d[6:0] = E5M2_INF;
                ClsZero: fp8_d[6:0] = 7'h00;
                default: begin
                    if (sum >= {1'b0, E5M2_INF}) begin
                        fp8_d[6:0] = E5M2_MAX;
                        sat_d      = 1'b1;
                    end else begin
                        fp8_d[6:0] = sum[6:0];
                    end
                end
            endcase
        end else begin
            case (s1_q.cls)
                ClsNan: fp8_d[6:0] = E4M3_NAN;
                ClsInf: begin
                    fp8_d[6:0] = E4M3_MAX;
                    sat_d      = 1'b1;
                end
                ClsNorm: begin
                    if (sum > {1'b0, E4M3_MAX}) begin
                        fp8_d[6:0] = E4M3_MAX;
                        sat_d      = 1'b1;
                    end else begin
                        fp8_d[6:0] = sum[6:0];
                    end
                end
                default: fp8_d[6:0] = 7'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fp8_q <= 8'h00;
            sat_q <= 1'b0;
        end else if (ld2_i) begin
            fp8_q <= fp8_d;
            sat_q <= sat_d;
        end
    end

    assign fp8_o = fp8_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/fp16_fp8_requant_pipe.sv
// Six-lane FP16 -> FP8 requantiser: 2-stage valid/ready pipeline plus saturation-event counter.
module fp16_fp8_requant_pipe #(
    parameter int unsigned LANES = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*LANES-1:0]  in_data,
    input  logic                 e5m2mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [CNT_W-1:0]     sat_count,
    input  logic                 sat_clear
);

    logic             s1_valid_q, s2_valid_q;
    logic             adv1, adv2, ld1, ld2;
    logic [LANES-1:0] lane_sat;
    logic [CNT_W:0]   sat_pop, cnt_sum;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign adv2      = ~s2_valid_q | out_ready;
    assign adv1      = ~s1_valid_q | adv2;
    assign in_ready  = adv1;
    assign ld1       = adv1 & in_valid;
    assign ld2       = adv2 & s1_valid_q;
    assign out_valid = s2_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (adv1) s1_valid_q <= in_valid;
            if (adv2) s2_valid_q <= s1_valid_q;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fp16_fp8_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .ld1_i  (ld1),
            .ld2_i  (ld2),
            .fp16_i (in_data[16*g +: 16]),
            .e5m2_i (e5m2mode),
            .fp8_o  (out_data[8*g +: 8]),
            .sat_o  (lane_sat[g])
        );
    end

    always_comb begin
        sat_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            sat_pop = sat_pop + {{CNT_W{1'b0}}, lane_sat[i]};
        end
        cnt_sum = {1'b0, cnt_q} + sat_pop;
        cnt_d   = cnt_q;
        if (sat_clear) begin
            cnt_d = '0;
        end else if (out_valid && out_ready) begin
            cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_count = cnt_q;

endmodule

// File: tb/tb_fp16_fp8_requant_pipe.sv
// Directed bench for fp16_fp8_requant_pipe: conversion vectors, handshake, counter and reset.
module tb_fp16_fp8_requant_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        e5m2mode = 1'b0;
    logic        out_ready = 1'b0;
    logic        sat_clear = 1'b0;
    logic [95:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [47:0] out_data;
    logic [15:0] sat_count;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] exp_cnt = '0;

    logic [95:0] bd [64];
    logic        bm [64];
    logic [47:0] got [64];
    int          xc [64];
    int          ngot;
    logic        rdy_hist [8];

    always #5 clk = ~clk;

    fp16_fp8_requant_pipe #(
        .LANES (6),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .e5m2mode  (e5m2mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_count (sat_count),
        .sat_clear (sat_clear)
    );

    // Ramp beat k: lane j = 2^(k-3) * (1 + j/8), exact in E4M3.
    function automatic logic [95:0] ramp_in(int k);
        logic [95:0] v;
        for (int j = 0; j < 6; j++) v[16*j +: 16] = 16'h3000 + 16'(k << 10) + 16'(j << 7);
        return v;
    endfunction

    function automatic logic [47:0] ramp_out(int k, logic mode);
        logic [47:0] v;
        int e5_tab [6] = '{0, 0, 1, 2, 2, 2};
        for (int j = 0; j < 6; j++) begin
            if (!mode) v[8*j +: 8] = 8'(((4 + k) << 3) + j);
            else       v[8*j +: 8] = 8'(((12 + k) << 2) + e5_tab[j]);
        end
        return v;
    endfunction

    function automatic logic [95:0] splat(logic [15:0] h);
        return {6{h}};
    endfunction

    // policy: 0 ready always, 1 random ready, 2 ready low for the first 5 cycles
    task automatic run_stream(input int n, input int policy, output bit timed_out);
        int sent = 0;
        int cyc = 0;
        int idx;
        ngot = 0;
        while ((sent < n || ngot < n) && cyc < 4 * n + 50) begin
            @(posedge clk); #1;
            case (policy)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = (cyc >= 5);
                default: out_ready = 1'b1;
            endcase
            idx      = (n > 64) ? 0 : sent;
            in_valid = (sent < n);
            if (sent < n) begin
                in_data  = bd[idx];
                e5m2mode = bm[idx];
            end
            @(negedge clk);
            if (cyc < 8) rdy_hist[cyc] = in_ready;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                if (ngot < 64) begin
                    got[ngot] = out_data;
                    xc[ngot]  = cyc;
                end
                ngot++;
            end
            cyc++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        timed_out = (ngot < n);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset out_valid: got %b expected 0", out_valid);
        end
        tests_run++;
        if (out_data !== 48'h0) begin
            tests_failed++; $display("FAIL reset out_data: got %h expected 0", out_data);
        end
        tests_run++;
        if (sat_count !== 16'h0) begin
            tests_failed++; $display("FAIL reset sat_count: got %h expected 0", sat_count);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_e4m3_exact();
        bit to;
        bd[0] = {16'h4000, 16'h8000, 16'h0000, 16'hC200, 16'h4600, 16'h3C00};
        bm[0] = 1'b0;
        run_stream(1, 0, to);
        tests_run++;
        if (to) begin
            tests_failed++; $display("FAIL e4m3_exact timeout: got %0d beats expected 1", ngot);
        end
        tests_run++;
        if (got[0] !== 48'h40_80_00_C4_4C_38) begin
            tests_failed++; $display("FAIL e4m3_exact data: got %h expected 408000c44c38", got[0]);
        end
        tests_run++;
        if (xc[0] !== 2) begin
            tests_failed++; $display("FAIL e4m3_exact latency: got %0d expected 2", xc[0]);
        end
        tests_run++;
        if (sat_count !== exp_cnt) begin
            tests_failed++; $display("FAIL e4m3_exact sat_count: got %h expected %h", sat_count, exp_cnt);
        end
    endtask

    task automatic test_rne_ties();
        bit to;
        bd[0] = {16'h1401, 16'h9400, 16'h0200, 16'h1800, 16'h3CC0, 16'h3C40};
        bm[0] = 1'b0;
        run_stream(1, 0, to);
        tests_run++;
        if (to || got[0] !== 48'h01_80_00_01_3A_38) begin
            tests_failed++; $display("FAIL rne_ties data: got %h expected 018000013a38", got[0]);
        end
        tests_run++;
        if (sat_count !== exp_cnt) begin
            tests_failed++; $display("FAIL rne_ties sat_count: got %h expected %h", sat_count, exp_cnt);
        end
    endtask

    task automatic test_e4m3_sat();
        bit to;
        bd[0] = {16'h3C00, 16'h7E00, 16'hFC00, 16'h6000, 16'h5F80, 16'h5F00};
        bm[0] = 1'b0;
        run_stream(1, 0, to);
        exp_cnt = exp_cnt + 16'd3;
        tests_run++;
        if (to || got[0] !== 48'h38_7F_FE_7E_7E_7E) begin
            tests_failed++; $display("FAIL e4m3_sat data: got %h expected 387ffe7e7e7e", got[0]);
        end
        tests_run++;
        if (sat_count !== exp_cnt) begin
            tests_failed++; $display("FAIL e4m3_sat sat_count: got %h expected %h", sat_count, exp_cnt);
        end
    endtask

    task automatic test_e5m2();
        bit to;
        bd[0] = {16'h0180, 16'hC200, 16'h7BFF, 16'h7E00, 16'h7C00, 16'h3C00};
        bm[0] = 1'b1;
        run_stream(1, 0, to);
        exp_cnt = exp_cnt + 16'd1;
        tests_run++;
        if (to || got[0] !== 48'h02_C2_7B_7E_7C_3C) begin
            tests_failed++; $display("FAIL e5m2 data: got %h expected 02c27b7e7c3c", got[0]);
        end
        tests_run++;
        if (sat_count !== exp_cnt) begin
            tests_failed++; $display("FAIL e5m2 sat_count: got %h expected %h", sat_count, exp_cnt);
        end
    endtask

    task automatic test_mode_alternate();
        bit to;
        logic [47:0] exp_b;
        for (int i = 0; i < 4; i++) begin
            bd[i] = {16'h0000, 16'h3800, 16'h4000, 16'hC200, 16'h4600, 16'h3C00};
            bm[i] = 1'(i % 2);
        end
        run_stream(4, 0, to);
        tests_run++;
        if (to) begin
            tests_failed++; $display("FAIL mode_alt timeout: got %0d beats expected 4", ngot);
        end
        for (int i = 0; i < 4; i++) begin
            exp_b = bm[i] ? 48'h00_38_40_C2_46_3C : 48'h00_30_40_C4_4C_38;
            tests_run++;
            if (got[i] !== exp_b) begin
                tests_failed++; $display("FAIL mode_alt beat%0d: got %h expected %h", i, got[i], exp_b);
            end
            tests_run++;
            if (xc[i] !== 2 + i) begin
                tests_failed++; $display("FAIL mode_alt cycle%0d: got %0d expected %0d", i, xc[i], 2 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic rdy_exp [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            bd[k] = ramp_in(k);
            bm[k] = 1'b0;
        end
        run_stream(6, 2, to);
        tests_run++;
        if (to) begin
            tests_failed++; $display("FAIL backpressure timeout: got %0d beats expected 6", ngot);
        end
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (rdy_hist[c] !== rdy_exp[c]) begin
                tests_failed++;
                $display("FAIL backpressure in_ready c%0d: got %b expected %b", c, rdy_hist[c], rdy_exp[c]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (got[k] !== ramp_out(k, 1'b0) || xc[k] !== 5 + k) begin
                tests_failed++;
                $display("FAIL backpressure beat%0d: got %h @%0d expected %h @%0d",
                         k, got[k], xc[k], ramp_out(k, 1'b0), 5 + k);
            end
        end
    endtask

    task automatic test_random_ready();
        bit to;
        for (int k = 0; k < 12; k++) begin
            bd[k] = ramp_in(k);
            bm[k] = 1'(k % 2);
        end
        run_stream(12, 1, to);
        tests_run++;
        if (to) begin
            tests_failed++; $display("FAIL random_ready timeout: got %0d beats expected 12", ngot);
        end
        for (int k = 0; k < 12; k++) begin
            tests_run++;
            if (got[k] !== ramp_out(k, bm[k])) begin
                tests_failed++;
                $display("FAIL random_ready beat%0d: got %h expected %h", k, got[k], ramp_out(k, bm[k]));
            end
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL random_ready extra beat: got out_valid %b expected 0", out_valid);
        end
        tests_run++;
        if (sat_count !== exp_cnt) begin
            tests_failed++; $display("FAIL random_ready sat_count: got %h expected %h", sat_count, exp_cnt);
        end
    endtask

    task automatic test_counter_saturate();
        bit to;
        @(posedge clk); #1 sat_clear = 1'b1;
        @(posedge clk); #1 sat_clear = 1'b0;
        tests_run++;
        if (sat_count !== 16'h0) begin
            tests_failed++; $display("FAIL sat_clear: got %h expected 0000", sat_count);
        end
        bd[0] = splat(16'h7C00);
        bm[0] = 1'b0;
        run_stream(10922, 0, to);
        tests_run++;
        if (to || sat_count !== 16'd65532) begin
            tests_failed++; $display("FAIL counter near-full: got %h expected fffc", sat_count);
        end
        run_stream(1, 0, to);
        tests_run++;
        if (to || sat_count !== 16'hFFFF) begin
            tests_failed++; $display("FAIL counter stick: got %h expected ffff", sat_count);
        end
        run_stream(2, 0, to);
        tests_run++;
        if (to || sat_count !== 16'hFFFF) begin
            tests_failed++; $display("FAIL counter hold: got %h expected ffff", sat_count);
        end
    endtask

    task automatic test_clear_priority();
        bit seen = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = splat(16'h7C00);
        e5m2mode  = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        sat_clear = 1'b1;
        @(posedge clk); #1 sat_clear = 1'b0;
        exp_cnt = 16'h0;
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL clear_priority timeout: got no out_valid expected 1");
        end
        tests_run++;
        if (sat_count !== 16'h0) begin
            tests_failed++; $display("FAIL clear_priority sat_count: got %h expected 0000", sat_count);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL clear_priority drain: got out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        bit to;
        bit seen = 1'b0;
        bd[0] = splat(16'h7C00);
        bm[0] = 1'b0;
        run_stream(1, 0, to);
        tests_run++;
        if (to || sat_count !== 16'd6) begin
            tests_failed++; $display("FAIL midstream precount: got %h expected 0006", sat_count);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = ramp_in(1);
        @(posedge clk); #1 in_data = ramp_in(2);
        @(posedge clk); #1 in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL midstream prefill: got out_valid %b expected 1", out_valid);
        end
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 48'h0 || sat_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL midstream reset: got valid %b data %h cnt %h expected 0 0 0",
                     out_valid, out_data, sat_count);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++; $display("FAIL midstream dropped beats: got out_valid 1 expected 0");
        end
    endtask

    initial begin
        test_reset();
        test_e4m3_exact();
        test_rne_ties();
        test_e4m3_sat();
        test_e5m2();
        test_mode_alternate();
        test_backpressure();
        test_random_ready();
        test_counter_saturate();
        test_clear_priority();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fp16_fp8_requant_pipe.md
Name: fp16_fp8_requant_pipe

Overview:
- Return-path encoder for the FP8 vector multiplier. It takes one beat of six FP16 lanes (the multiplier's qa..kc products) and re-encodes each lane to FP8, either E4M3 or E5M2.
- Each lane uses round-to-nearest-even and saturates on overflow.
- It is a 2-stage valid/ready pipeline with backpressure, plus a saturation-event counter for quantisation monitoring.
- It sits between the multiplier outputs and the FP8 operand buffers, so products can be fed back as FP8 operands.

Parameters:
- LANES, 6, number of FP16->FP8 lanes per beat.
- CNT_W, 16, width of sat_count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  16*LANES  FP16 lanes (1/5/10, bias 15); lane i is in_data[16i+15:16i].
- e5m2mode  in  1  format select, sampled with the beat: 0 = E4M3, 1 = E5M2.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8*LANES  FP8 lanes; lane i is out_data[8i+7:8i].
- sat_count  out  CNT_W  running count of saturated lanes.
- sat_clear  in  1  synchronous clear of sat_count.

Behaviour:
- Reset values: out_valid=0, out_data=0, sat_count=0, both pipeline stage valids=0. in_ready is 1 after reset.
- Pipeline control:
  - adv2 = ~s2_valid | out_ready
  - adv1 = ~s1_valid | adv2
  - in_ready = adv1 (a combinational path from out_ready is allowed).
- Transfers: an input transfer occurs on in_valid & in_ready; an output transfer occurs on out_valid & out_ready.
- Latency: 2 cycles from input transfer to out_valid when not stalled. Throughput is 1 beat/cycle.
- Stalls: when stalled, stage contents are held, with no loss, duplication or reordering. The registered e5m2mode travels with its beat.
- Stage 1: per lane, unpack sign/exp/mantissa, classify (zero, FP16 subnormal, normal, Inf, NaN), compute the target exponent, and compute guard/round/sticky bits.
- Stage 2: RNE increment, mantissa-carry exponent bump, overflow clamp, pack. out_data is the stage-2 register.
- E4M3 target (bias 7, no Inf):
  - NaN input -> S.1111.111 (0x7F|S<<7).
  - Inf input or finite magnitude rounding above 448 -> S.1111.110 (saturate).
  - Target exponent <=0 -> E4M3 subnormal with RNE (minimum subnormal 2^-9).
  - FP16 subnormal inputs and anything rounding below 2^-10 -> signed zero.
- E5M2 target (bias 15, same exponent as FP16):
  - Round the 10-bit mantissa to 2 bits with RNE. FP16 subnormals map to E5M2 subnormals.
  - Inf -> S.11111.00. NaN -> S.11111.10.
  - Finite values rounding to >=65536 -> S.11110.11 (57344, saturate).
- Saturation counting:
  - A lane counts as saturated only if it is a finite input that is clamped, or an E4M3 Inf input. Exact 448 and 57344 do not count.
  - On each output transfer, sat_count += number of saturated lanes in the beat (0..LANES). The count sticks at all-ones and does not wrap.
  - sat_clear has priority over an increment in the same cycle.
- Signed zero is preserved: 0x8000 -> 0x80.
- Reset mid-stream: all in-flight beats are dropped, out_valid deasserts immediately (asynchronous), and sat_count clears.

Decomposition:
- Shared package fp8_pkg holds:
  - format constants: FP16 bias 15, E4M3 bias 7, E4M3 max code 7'h7E, E4M3 NaN 7'h7F, E5M2 max 7'h7B, E5M2 Inf 7'h7C, E5M2 NaN 7'h7E;
  - the lane-class enum (ZERO, SUB, NORM, INF, NAN).
- One natural sub-module, fp16_fp8_lane: a single-lane converter split into stage-1 and stage-2 logic, with a registered-boundary output. It is instantiated LANES times.
- The top level contains only the handshake, the valid registers and the saturation counter.

Test Plan:
1. E4M3 exact: lanes 0x3C00, 0x4600, 0xC200, 0x0000, 0x8000, 0x4000 -> 0x38, 0x4C, 0xC4, 0x00, 0x80, 0x40. out_valid exactly 2 cycles after acceptance; sat_count stays 0.
2. RNE ties (E4M3): 0x3C40 (1.0625) -> 0x38; 0x3CC0 (1.1875) -> 0x3A; 0x1800 (2^-9) -> 0x01; 0x0200 (FP16 subnormal) -> 0x00.
3. E4M3 saturation: 0x5F00 (448) -> 0x7E with no count; 0x5F80 (480) -> 0x7E; 0x6000 -> 0x7E; 0xFC00 -> 0xFE; 0x7E00 -> 0x7F. sat_count = 3 after the beat.
4. E5M2: 0x3C00 -> 0x3C; 0x7C00 -> 0x7C; 0x7E00 -> 0x7E; 0x7BFF -> 0x7B (sat_count +1); 0xC200 -> 0xC2. Then alternate e5m2mode per beat and confirm each beat uses its own mode.
5. Backpressure: stream 6 distinct beats with out_ready held low for 5 cycles. in_ready drops after 2 beats are held; on release all 6 emerge in order with no gaps or duplicates. Also drive random out_ready against a scoreboard.
6. Counter and reset: saturate until sat_count = 0xFFFF and confirm it holds; assert sat_clear together with a saturating beat -> 0. Assert rst with 2 beats in flight -> out_valid=0 immediately, and the beats are never emitted.
